// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo sequencer for HC-SR04-style rangers sharing one echo timer.
// Each sensor in turn goes TRIG -> WAIT_RISE -> MEASURE -> HOLDOFF and reports one tagged result.
module ultrasonic_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int HOLDOFF_CYCLES = 3_000_000,
  parameter int CNT_W          = 22,
  localparam int SEL_W         = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [SEL_W-1:0]       sensor_sel,
  output logic                   dist_valid,
  output logic [SEL_W-1:0]       dist_id,
  output logic [CNT_W-1:0]       dist_cycles,
  output logic                   timeout,
  output logic [2:0]             dbg_state
);

  // The phase counter times both the trigger pulse and the holdoff gap.
  localparam int PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SENSORS - 1);
  localparam logic [NUM_SENSORS-1:0] ONE_HOT0 = {{(NUM_SENSORS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [NUM_SENSORS-1:0] r_sync1;
  logic [NUM_SENSORS-1:0] r_sync2;
  logic [NUM_SENSORS-1:0] r_prev;
  logic [NUM_SENSORS-1:0] r_trig;
  logic [PH_W-1:0]        r_phase;
  logic [CNT_W-1:0]       r_tcnt;
  logic [CNT_W-1:0]       r_width;
  logic [SEL_W-1:0]       r_sel;
  logic                   r_valid;
  logic [SEL_W-1:0]       r_id;
  logic [CNT_W-1:0]       r_cycles;
  logic                   r_timeout;

  logic                   w_echo;
  logic                   w_echo_d;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_tmo_hit;
  logic [SEL_W-1:0]       w_sel_next;
  logic [CNT_W-1:0]       w_width_inc;

  assign w_echo      = r_sync2[r_sel];
  assign w_echo_d    = r_prev[r_sel];
  assign w_rise      = w_echo & ~w_echo_d;
  assign w_fall      = ~w_echo & w_echo_d;
  assign w_tmo_hit   = (r_tcnt == TMO_LAST);
  assign w_sel_next  = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
  assign w_width_inc = (&r_width) ? r_width : r_width + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_trig    <= '0;
      r_phase   <= '0;
      r_tcnt    <= '0;
      r_width   <= '0;
      r_sel     <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_sync1 <= echo;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_TRIG;
            r_trig  <= ONE_HOT0 << r_sel;
            r_phase <= '0;
          end
        end
        S_TRIG: begin
          if (r_phase == TRIG_LAST) begin
            r_state <= S_WAIT_RISE;
            r_trig  <= '0;
            r_tcnt  <= '0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_WAIT_RISE: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (w_tmo_hit) begin
            r_state   <= S_HOLDOFF;
            r_phase   <= '0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
            r_id      <= r_sel;
            r_cycles  <= '1;
          end else if (w_rise) begin
            r_state <= S_MEASURE;
            r_width <= CNT_W'(1);
          end
        end
        S_MEASURE: begin
          r_tcnt <= r_tcnt + 1'b1;
          // Timeout takes priority over a falling edge landing on the same cycle.
          if (w_tmo_hit) begin
            r_state   <= S_HOLDOFF;
            r_phase   <= '0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
            r_id      <= r_sel;
            r_cycles  <= '1;
          end else if (w_fall) begin
            r_state   <= S_HOLDOFF;
            r_phase   <= '0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b0;
            r_id      <= r_sel;
            r_cycles  <= r_width;
          end else if (w_echo) begin
            r_width <= w_width_inc;
          end
        end
        S_HOLDOFF: begin
          if (r_phase == HOLD_LAST) begin
            r_sel <= w_sel_next;
            if (enable) begin
              r_state <= S_TRIG;
              r_trig  <= ONE_HOT0 << w_sel_next;
              r_phase <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_trig  <= '0;
        end
      endcase
    end
  end

  assign trig        = r_trig;
  assign sensor_sel  = r_sel;
  assign dist_valid  = r_valid;
  assign dist_id     = r_id;
  assign dist_cycles = r_cycles;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed-plus-random bench for ultrasonic_scheduler; results are predicted from
// echo delay/width arithmetic and matched in order against the tagged result strobes.
module tb_ultrasonic_scheduler;

  localparam int EW = 43;  // {valid_cycle[31:0], id[1:0], timeout, cycles[7:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] echo;
  logic [3:0] trig;
  logic [1:0] sensor_sel;
  logic       dist_valid;
  logic [1:0] dist_id;
  logic [7:0] dist_cycles;
  logic       timeout;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_rise = 0;
  int exp_sel  = 0;
  int onehot_viol = 0;
  bit watch_measure = 1'b0;
  bit saw_measure   = 1'b0;
  logic [EW-1:0] exp_q[$];

  ultrasonic_scheduler #(
    .NUM_SENSORS(4), .TRIG_CYCLES(10), .TIMEOUT_CYCLES(200),
    .HOLDOFF_CYCLES(50), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .sensor_sel(sensor_sel), .dist_valid(dist_valid), .dist_id(dist_id),
    .dist_cycles(dist_cycles), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic finish_report();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic wait_trig_rise(output int t_rise);
    int n = 0;
    while (trig == 4'd0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (trig == 4'd0) begin
      check("trig_rise_wait", 64'd0, 64'd1);
      finish_report();
    end
    t_rise = cyc;
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      check("result_wait", 64'd0, 64'd1);
      finish_report();
    end
  endtask

  // One measurement: d cycles after trig falls the echo goes high for w cycles (w=0: no drive).
  task automatic do_meas(input int d, input int w, input bit xtalk, input bit drop);
    int t_rise, t_fall, n, delta, cur, x;
    bit norm;
    logic [EW-1:0] e;
    wait_trig_rise(t_rise);
    check("trig_rise_cycle", 64'(t_rise), 64'(exp_rise));
    check("trig_bit", 64'(trig), 64'(4'b0001 << exp_sel));
    check("sensor_sel", 64'(sensor_sel), 64'(exp_sel));
    n = 0;
    while (trig != 4'd0 && n < 100) begin @(posedge clk); #1; n++; end
    t_fall = cyc;
    check("trig_width", 64'(t_fall - t_rise), 64'd10);
    norm  = (w > 0) && (d + w + 3 <= 199);
    delta = norm ? d + w + 3 : 200;
    e = {32'(t_fall + delta), 2'(exp_sel), ~norm, norm ? 8'(w) : 8'hFF};
    exp_q.push_back(e);
    cur = exp_sel;
    exp_sel = (exp_sel + 1) % 4;
    x = (cur + 3) % 4;
    if (w > 0) begin
      repeat (d) begin @(posedge clk); #1; end
      echo[cur] = 1'b1;
      fork
        begin
          for (int i = 0; i < w; i++) begin
            @(posedge clk); #1;
            if (drop && i == 5) enable = 1'b0;
          end
          echo[cur] = 1'b0;
        end
        begin
          if (xtalk) begin
            for (int j = 0; j < 10; j++) begin
              @(posedge clk); #1;
              echo[x] = ~echo[x];
              @(posedge clk); #1;
            end
            echo[x] = 1'b0;
          end
        end
      join
    end
  endtask

  // scoreboard: in-order match of result strobes against predicted results
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if ($countones(trig) > 1) onehot_viol++;
      if (watch_measure && dbg_state == 3'd3) saw_measure = 1'b1;
      if (dist_valid) begin
        exp_rise = cyc + 51;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("dist_cycles", 64'(dist_cycles), 64'(e[7:0]));
          check("timeout", 64'(timeout), 64'(e[8]));
          check("dist_id", 64'(dist_id), 64'(e[10:9]));
          check("valid_cycle", 64'(cyc), 64'(e[42:11]));
        end
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1; enable = 1'b0; echo = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_sel", 64'(sensor_sel), 64'd0);
    check("rst_valid", 64'(dist_valid), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_id", 64'(dist_id), 64'd0);
    check("rst_cycles", 64'(dist_cycles), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    exp_rise = cyc + 1;

    do_meas(20, 37, 1'b0, 1'b0);   // single measurement, sensor 0
    do_meas(0, 0, 1'b0, 1'b0);     // no echo, sensor 1
    echo[2] = 1'b1;                // stuck high before its trigger
    saw_measure = 1'b0;
    watch_measure = 1'b1;
    do_meas(0, 0, 1'b0, 1'b0);
    wait_q_empty();
    check("stuck_no_measure", 64'(saw_measure), 64'd0);
    watch_measure = 1'b0;
    echo[2] = 1'b0;
    do_meas($urandom_range(0, 40), $urandom_range(1, 150), 1'b0, 1'b0);
    do_meas(0, 240, 1'b0, 1'b0);   // echo longer than the timeout
    do_meas(10, 186, 1'b0, 1'b0);  // falls one cycle before timeout
    do_meas(10, 187, 1'b0, 1'b0);  // fall and timeout coincide
    do_meas(5, 1, 1'b0, 1'b0);     // minimum width
    for (int k = 0; k < 4; k++) do_meas($urandom_range(0, 30), 15, 1'b0, 1'b0);
    do_meas(8, 40, 1'b1, 1'b0);    // sensor 0 with crosstalk on sensor 3
    for (int k = 0; k < 8; k++)
      do_meas($urandom_range(0, 30), $urandom_range(1, 210), 1'b0, 1'b0);

    do_meas(5, 30, 1'b0, 1'b1);    // enable dropped during MEASURE
    wait_q_empty();
    repeat (60) @(posedge clk);
    #1;
    check("drop_idle_state", 64'(dbg_state), 64'd0);
    check("drop_idle_trig", 64'(trig), 64'd0);
    check("drop_sel_adv", 64'(sensor_sel), 64'(exp_sel));
    enable = 1'b1;
    exp_rise = cyc + 1;

    wait_trig_rise(t);             // reset in the middle of TRIG
    check("pre_rst_rise", 64'(t), 64'(exp_rise));
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_trig", 64'(trig), 64'd0);
    check("mid_rst_sel", 64'(sensor_sel), 64'd0);
    check("mid_rst_valid", 64'(dist_valid), 64'd0);
    check("mid_rst_timeout", 64'(timeout), 64'd0);
    check("mid_rst_id", 64'(dist_id), 64'd0);
    check("mid_rst_cycles", 64'(dist_cycles), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    exp_sel = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rise = cyc + 1;
    do_meas(12, 25, 1'b0, 1'b0);
    wait_q_empty();

    check("trig_onehot", 64'(onehot_viol), 64'd0);
    finish_report();
  end

endmodule

// File: doc/ultrasonic_scheduler.md
# ultrasonic_scheduler

Round-robin measurement sequencer for up to NUM_SENSORS HC-SR04-style ultrasonic rangers that share one echo-width measurement datapath. The block sits between the GPIO pins and the distance/display logic in the proximity-sensor top level. For each sensor in turn it does four things:
- issues the trigger pulse
- synchronises and times the selected echo
- enforces a per-measurement timeout
- enforces an inter-measurement holdoff
It reports each result as a one-cycle tagged pulse.

## Interface
- NUM_SENSORS, 4, number of sensors sequenced (2..8)
- TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
- TIMEOUT_CYCLES, 1_500_000, max clocks from trigger fall to echo fall (30 ms)
- HOLDOFF_CYCLES, 3_000_000, quiet clocks after each result before next trigger
- CNT_W, 22, width of echo/timeout counters; must hold TIMEOUT_CYCLES
- clk  input  1  system clock (CLOCK_50 at top level)
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run scheduling; sampled only in IDLE and at end of HOLDOFF
- echo  input  NUM_SENSORS  raw asynchronous echo lines
- trig  output  NUM_SENSORS  trigger outputs; at most one bit high
- sensor_sel  output  $clog2(NUM_SENSORS)  index of the sensor currently being serviced
- dist_valid  output  1  one-cycle result strobe
- dist_id  output  $clog2(NUM_SENSORS)  sensor index of the result; held until the next strobe
- dist_cycles  output  CNT_W  echo high width in clocks; held until the next strobe
- timeout  output  1  qualifies dist_valid; the result is a timeout

## Operation
- All echo bits pass through a 2-flop synchroniser. Edge detection compares the synchronised value with its 1-cycle-delayed copy. Only echo[sensor_sel] is observed; all other echo bits are ignored.
- States:
  - IDLE: trig = 0.
  - TRIG: trig[sensor_sel] = 1.
  - WAIT_RISE: wait for a synchronised rising edge.
  - MEASURE: count while synchronised echo is high.
  - HOLDOFF: wait out the holdoff period.
- Transitions:
  - IDLE -> TRIG when enable = 1.
  - TRIG -> WAIT_RISE after exactly TRIG_CYCLES cycles.
  - WAIT_RISE -> MEASURE on a rising edge. Echo already high on entry does not count; a low-then-high transition is required.
  - MEASURE -> HOLDOFF on a falling edge.
  - WAIT_RISE/MEASURE -> HOLDOFF when the timeout counter reaches TIMEOUT_CYCLES.
  - HOLDOFF -> TRIG (enable = 1) or IDLE (enable = 0) after HOLDOFF_CYCLES.
- Timeout counter: cleared on TRIG exit; runs through WAIT_RISE and MEASURE.
- Width counter: loaded with 1 on the rising-edge cycle; increments each cycle in MEASURE while echo is high; saturates at all-ones.
- Results:
  - Normal result on HOLDOFF entry: dist_valid = 1, timeout = 0, dist_cycles = width count, dist_id = sensor_sel.
  - Timeout result: dist_valid = 1, timeout = 1, dist_cycles = {CNT_W{1'b1}}.
- sensor_sel increments on HOLDOFF exit and wraps from NUM_SENSORS-1 to 0. It does not advance when leaving IDLE.
- Deasserting enable mid-measurement does not abort. The current measurement completes, including its result and full HOLDOFF, and the block then goes to IDLE with sensor_sel advanced.
- Reset, asynchronous, including mid-operation:
  - state = IDLE; trig = 0 immediately, with no glitch beyond the reset assertion.
  - sensor_sel = 0, dist_valid = 0, timeout = 0, dist_id = 0, dist_cycles = 0.
  - All counters and synchroniser flops are cleared.

## Timing
- enable is sampled high in IDLE at cycle N. At cycle N+1 the block is in TRIG and trig[sensor_sel] rises. trig stays high for exactly TRIG_CYCLES cycles.
- Echo path latency: raw echo edge to synchronised edge detect is 2 cycles.
- Echo held high for exactly W synchronous cycles gives dist_cycles = W, for W >= 1.
- dist_valid asserts 3 cycles after raw echo falls, and lasts exactly 1 cycle.
- Timeout strobe: dist_valid asserts on the cycle the timeout counter reaches TIMEOUT_CYCLES, counted from the first cycle after trig falls.
- Holdoff: the next trig rises exactly HOLDOFF_CYCLES+1 cycles after the dist_valid cycle.
- Simultaneous events: if a falling edge and the timeout occur in the same cycle, timeout wins and timeout = 1.
- trig is a registered output.

## Test plan
Parameters for all scenarios: NUM_SENSORS=4, TRIG_CYCLES=10, TIMEOUT_CYCLES=200, HOLDOFF_CYCLES=50, CNT_W=8.
- Single measurement:
  - Stimulus: reset, enable = 1; drive echo[0] high 20 cycles after trig[0] falls, for 37 cycles.
  - Required response: trig[0] high exactly 10 cycles; dist_valid pulse 3 cycles after echo falls with dist_id = 0, dist_cycles = 37, timeout = 0.
- Round robin:
  - Stimulus: all four sensors return 15-cycle echoes; continuous enable.
  - Required response: dist_id sequence 0, 1, 2, 3, 0; never more than one trig bit high; 51 cycles from each dist_valid to the next trig rise.
- No echo:
  - Stimulus: echo[1] held low.
  - Required response: dist_valid with timeout = 1, dist_cycles = 8'hFF, exactly 200 cycles after trig[1] falls.
- Stuck-high and long echo:
  - Stimulus: echo[2] high before trig; separately, a 250-cycle echo.
  - Required response: both report timeout = 1; the stuck echo never enters MEASURE.
- Crosstalk:
  - Stimulus: toggle echo[3] while sensor 0 is being measured.
  - Required response: sensor 0 result unaffected.
- Enable drop and reset:
  - Stimulus (enable drop): drop enable during MEASURE.
  - Required response: result still reported, block returns to IDLE, sensor_sel = 1.
  - Stimulus (reset): assert reset mid-TRIG.
  - Required response: trig = 0 within the reset cycle; all outputs at reset values.
